// File: rtl/lsu_ctrl.sv
// Load/store sequencer between decode/execute and a req/ack data bus.
// Builds strobes, replicates store data, extends loads, flags faults.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        MemWr,
   input  logic        MemtoReg,
   input  logic [2:0]  MemOp,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [1:0]        r_lane;
   logic [2:0]        r_op;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_bwd;
   logic [31:0]       r_rdata;
   logic [1:0]        r_fault;

   logic              w_accept;
   logic              w_is_half;
   logic              w_is_word;
   logic              w_illegal;
   logic              w_misal;
   logic [1:0]        w_fault;
   logic              w_bad;
   logic              w_timeout;
   logic [3:0]        w_be;
   logic [31:0]       w_bwd;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_ld;

   assign w_accept  = start && (MemWr || MemtoReg) &&
                      (r_state == S_IDLE || r_state == S_DONE);
   assign w_is_half = (MemOp[2:1] == 2'b01);
   assign w_is_word = (MemOp == 3'b100);

   assign w_illegal = (MemWr && MemtoReg) ||
                      (MemtoReg && MemOp > 3'd4) ||
                      (MemWr && !(MemOp == 3'b000 ||
                                  MemOp == 3'b010 ||
                                  MemOp == 3'b100));
   assign w_misal   = (w_is_half && addr[0]) ||
                      (w_is_word && addr[1:0] != 2'b00);
   assign w_fault   = w_illegal ? 2'b10 : (w_misal ? 2'b01 : 2'b00);
   assign w_bad     = (w_fault != 2'b00);

   // Counter value after this cycle; reaching the limit ends the access.
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                      (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

   always_comb begin
      w_be  = 4'b0001 << addr[1:0];
      w_bwd = {4{wdata[7:0]}};
      case (1'b1)
         w_is_word: begin
            w_be  = 4'b1111;
            w_bwd = wdata;
         end
         w_is_half: begin
            w_be  = 4'b0011 << {addr[1], 1'b0};
            w_bwd = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_byte = bus_rdata[8*r_lane +: 8];
   assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      w_ld = bus_rdata;
      case (r_op)
         3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ld = {24'd0, w_byte};
         3'b010:  w_ld = {{16{w_half[15]}}, w_half};
         3'b011:  w_ld = {16'd0, w_half};
         default: w_ld = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = w_bad ? S_DONE : S_REQ;
            else          w_next = S_IDLE;
         end
         S_REQ: begin
            if (bus_ack || w_timeout) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_lane  <= 2'b00;
         r_op    <= 3'b000;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_be    <= 4'd0;
         r_bwd   <= 32'd0;
         r_rdata <= 32'd0;
         r_fault <= 2'b00;
      end else if (w_accept) begin
         r_cnt  <= '0;
         r_lane <= addr[1:0];
         r_op   <= MemOp;
         r_we   <= MemWr;
         r_addr <= {addr[31:2], 2'b00};
         r_be   <= w_be;
         r_bwd  <= w_bwd;
         if (w_bad) begin
            r_rdata <= 32'd0;
            r_fault <= w_fault;
         end
      end else if (r_state == S_REQ) begin
         if (bus_ack) begin
            r_rdata <= r_we ? 32'd0 : w_ld;
            r_fault <= 2'b00;
         end else if (w_timeout) begin
            r_rdata <= 32'd0;
            r_fault <= 2'b11;
         end else begin
            r_cnt <= w_cnt_inc;
         end
      end
   end

   assign stall     = w_accept || (r_state == S_REQ);
   assign done      = (r_state == S_DONE);
   assign bus_req   = (r_state == S_REQ);
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_be    = r_be;
   assign bus_wdata = r_bwd;
   assign rdata     = r_rdata;
   assign fault     = r_fault;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; completions checked against a queue.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        MemWr = 1'b0;
   logic        MemtoReg = 1'b0;
   logic [2:0]  MemOp = 3'b000;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   int total = 0;
   int bad = 0;
   logic [33:0] sb_q[$];

   always #5 clk = ~clk;

   lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .MemWr(MemWr),
      .MemtoReg(MemtoReg), .MemOp(MemOp), .addr(addr),
      .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [33:0] e;
            e = sb_q.pop_front();
            chk("sb_rdata", rdata, e[33:2]);
            chk("sb_fault", {30'd0, fault}, {30'd0, e[1:0]});
         end
      end
   end

   task automatic drive(input logic w, input logic r,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d);
      start = 1'b1; MemWr = w; MemtoReg = r;
      MemOp = op; addr = a; wdata = d;
   endtask

   task automatic release_in();
      start = 1'b0; MemWr = 1'b0; MemtoReg = 1'b0;
   endtask

   // Called just after a rising edge, in IDLE or DONE.
   task automatic access(input string tag, input logic w,
                         input logic r, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic legal, input int k,
                         input logic [31:0] brd,
                         input logic [3:0] xbe,
                         input logic [31:0] xbwd,
                         input logic [31:0] xrd,
                         input logic [1:0] xf);
      drive(w, r, op, a, d);
      sb_q.push_back({xrd, xf});
      #3;
      chk({tag, "_stall_acc"}, stall, 1);
      @(posedge clk); #1;
      release_in();
      if (legal) begin
         chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
         chk({tag, "_be"}, bus_be, xbe);
         chk({tag, "_we"}, bus_we, w);
         if (w) chk({tag, "_wdata"}, bus_wdata, xbwd);
         for (int i = 0; i <= k; i++) begin
            chk({tag, "_req"}, bus_req, 1);
            chk({tag, "_stall"}, stall, 1);
            chk({tag, "_done_early"}, done, 0);
            if (i == k) begin
               bus_ack = 1'b1;
               bus_rdata = brd;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
         end
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_req_off"}, bus_req, 0);
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, done, 0);
      chk({tag, "_stall_idle"}, stall, 0);
   endtask

   initial begin
      int n;
      #12;
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_fault", {30'd0, fault}, 0);
      chk("rst_be", bus_be, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_cycle("boot");

      access("sb", 1, 0, 3'b000, 32'h103, 32'hA5, 1, 2, 32'h0,
             4'b1000, 32'hA5A5A5A5, 32'h0, 2'b00);
      idle_cycle("sb");
      access("lb", 0, 1, 3'b000, 32'h102, 32'h0, 1, 1, 32'h12F45678,
             4'b0100, 32'h0, 32'hFFFFFFF4, 2'b00);
      idle_cycle("lb");
      access("lbu", 0, 1, 3'b001, 32'h102, 32'h0, 1, 0, 32'h12F45678,
             4'b0100, 32'h0, 32'h000000F4, 2'b00);
      idle_cycle("lbu");
      access("lh", 0, 1, 3'b010, 32'h102, 32'h0, 1, 0, 32'h12F45678,
             4'b1100, 32'h0, 32'h000012F4, 2'b00);
      idle_cycle("lh");
      access("lw", 0, 1, 3'b100, 32'h100, 32'h0, 1, 1, 32'h12F45678,
             4'b1111, 32'h0, 32'h12F45678, 2'b00);
      idle_cycle("lw");
      access("lhn", 0, 1, 3'b010, 32'h200, 32'h0, 1, 0, 32'h00008001,
             4'b0011, 32'h0, 32'hFFFF8001, 2'b00);
      idle_cycle("lhn");
      access("lhu", 0, 1, 3'b011, 32'h200, 32'h0, 1, 0, 32'h00008001,
             4'b0011, 32'h0, 32'h00008001, 2'b00);
      idle_cycle("lhu");
      access("sh", 1, 0, 3'b010, 32'h302, 32'h1234BEEF, 1, 0, 32'h0,
             4'b1100, 32'hBEEFBEEF, 32'h0, 2'b00);
      idle_cycle("sh");

      access("lw_mis", 0, 1, 3'b100, 32'h6, 32'h0, 0, 0, 32'h0,
             4'b0, 32'h0, 32'h0, 2'b01);
      idle_cycle("lw_mis");
      access("sh_mis", 1, 0, 3'b010, 32'h1, 32'h0, 0, 0, 32'h0,
             4'b0, 32'h0, 32'h0, 2'b01);
      idle_cycle("sh_mis");
      access("ld_op6", 0, 1, 3'b110, 32'h0, 32'h0, 0, 0, 32'h0,
             4'b0, 32'h0, 32'h0, 2'b10);
      idle_cycle("ld_op6");
      access("st_op1", 1, 0, 3'b001, 32'h0, 32'h0, 0, 0, 32'h0,
             4'b0, 32'h0, 32'h0, 2'b10);
      idle_cycle("st_op1");
      access("both", 1, 1, 3'b100, 32'h0, 32'h0, 0, 0, 32'h0,
             4'b0, 32'h0, 32'h0, 2'b10);
      idle_cycle("both");

      drive(0, 1, 3'b100, 32'h400, 32'h0);
      sb_q.push_back({32'h0, 2'b11});
      @(posedge clk); #1;
      release_in();
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) break;
         if (bus_req) n++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", n, 4);
      chk("to_done", done, 1);
      idle_cycle("to");
      access("to_ack4", 0, 1, 3'b100, 32'h400, 32'h0, 1, 3, 32'h55AA33CC,
             4'b1111, 32'h0, 32'h55AA33CC, 2'b00);

      access("b2b", 1, 0, 3'b100, 32'h500, 32'hDEADBEEF, 1, 0, 32'h0,
             4'b1111, 32'hDEADBEEF, 32'h0, 2'b00);
      idle_cycle("b2b");

      drive(0, 0, 3'b100, 32'h0, 32'h0);
      #3;
      chk("nop_stall", stall, 0);
      @(posedge clk); #1;
      release_in();
      chk("nop_req", bus_req, 0);
      chk("nop_done", done, 0);

      drive(0, 1, 3'b100, 32'h600, 32'h0);
      @(posedge clk); #1;
      release_in();
      chk("rr_req_pre", bus_req, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rr_req", bus_req, 0);
      chk("rr_stall", stall, 0);
      chk("rr_done", done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("rr_ack_req", bus_req, 0);
      chk("rr_ack_done", done, 0);
      access("rr_after", 0, 1, 3'b001, 32'h601, 32'h0, 1, 0, 32'h0000C300,
             4'b0010, 32'h0, 32'h000000C3, 2'b00);
      idle_cycle("rr_after");

      repeat (2) @(posedge clk);
      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
